pipeline_skid_reg: RTL

PIPELINE_SKID_REG -- requirements
Module: pipeline_skid_reg

---
 rtl/pipeline_skid_reg_pkg.sv | 22 ++
 rtl/pipeline_skid_reg_if.sv | 34 +++
 rtl/pipeline_skid_reg_entry.sv | 24 ++
 rtl/pipeline_skid_reg.sv | 109 ++++++++++
 4 files changed

// File: rtl/pipeline_skid_reg_pkg.sv
// Shared definitions for the pipeline stage registers: state encoding and default widths.
package pipeline_skid_reg_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CTRL_W = 17;

    // The encoding doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] occupancy_of(input skid_state_e s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_skid_reg_if.sv
// Upstream/downstream handshake bundle for a two-entry skid stage register.
interface pipeline_skid_reg_if
    import pipeline_skid_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W
) ();

    // Handshake: a word moves on an edge where valid and ready are both high;
    // the sender holds valid and payload stable until that edge, ready never
    // depends on valid in the same cycle, and Flush cancels any transfer.
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] InData;
    logic [CTRL_W-1:0] InCtrl;
    logic              Flush;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutData;
    logic [CTRL_W-1:0] OutCtrl;
    logic [1:0]        Occupancy;
    skid_state_e       DbgState;

    modport master (
        output InValid, InData, InCtrl, Flush, OutReady,
        input  InReady, OutValid, OutData, OutCtrl, Occupancy, DbgState
    );

    modport slave (
        input  InValid, InData, InCtrl, Flush, OutReady,
        output InReady, OutValid, OutData, OutCtrl, Occupancy, DbgState
    );

endinterface

// File: rtl/pipeline_skid_reg_entry.sv
// One payload slot of the skid stage: a plain register with load enable, cleared on reset.
module pipe_entry_reg #(
    parameter int W = 49
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipeline_skid_reg.sv
// Two-entry skid register between pipeline stages; MAIN drives the outputs, SKID
// absorbs the one word that arrives in the cycle downstream stalls.
module pipeline_skid_reg
    import pipeline_skid_reg_pkg::*;
#(
    parameter int                DATA_W      = DEFAULT_DATA_W,
    parameter int                CTRL_W      = DEFAULT_CTRL_W,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    pipeline_skid_reg_if.slave   bus
);

    localparam int ENTRY_W = DATA_W + CTRL_W;

    skid_state_e        r_state;
    skid_state_e        w_state_nxt;
    logic               r_in_ready;
    logic               w_accept;
    logic               w_drain;
    logic               w_out_valid;
    logic               w_main_load;
    logic               w_main_from_skid;
    logic               w_skid_load;
    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_main_d;
    logic [ENTRY_W-1:0] w_main_q;
    logic [ENTRY_W-1:0] w_skid_q;

    assign w_in_entry  = {bus.InData, bus.InCtrl};
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.InValid & r_in_ready & ~bus.Flush;
    assign w_drain     = w_out_valid & bus.OutReady;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (bus.Flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_skid_load = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                // InReady is low here, so only a drain can move the state.
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_nxt      = ST_ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_entry;

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    pipe_entry_reg #(.W(ENTRY_W)) u_main (
        .i_clk  (Clk),
        .i_rst  (Rst),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .i_clk  (Clk),
        .i_rst  (Rst),
        .i_load (w_skid_load),
        .i_d    (w_in_entry),
        .o_q    (w_skid_q)
    );

    assign bus.InReady   = r_in_ready;
    assign bus.OutValid  = w_out_valid;
    assign bus.OutData   = w_main_q[ENTRY_W-1:CTRL_W];
    assign bus.OutCtrl   = w_out_valid ? w_main_q[CTRL_W-1:0] : BUBBLE_CTRL;
    assign bus.Occupancy = occupancy_of(r_state);
    assign bus.DbgState  = r_state;

endmodule
